round_sat_pipe: RTL and testbench
=================================

ROUND_SAT_PIPE -- requirements
Module: round_sat_pipe

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, number of parallel lanes sharing one handshake (>=1).
REQ-002 SHALL have parameter WIDTH_IN, default 16, input lane width (>0).
REQ-003 SHALL have parameter WIDTH_OUT, default 8, output lane width (>0, <=WIDTH_IN; else elaboration $error).
REQ-004 SHALL have parameter IS_SIGNED, default 1, 1 = two's complement lanes, 0 = unsigned.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, saturation-event counter width.
REQ-006 clk  input  1  rising-edge clock for all logic.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-010 in_data  input  NUM_CH*WIDTH_IN  lane k at [k*WIDTH_IN +: WIDTH_IN].
REQ-011 in_mode  input  2  rounding mode, sampled with the beat: 0 TRUNC, 1 HALF_UP, 2 HALF_EVEN, 3 HALF_AWAY.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-014 out_data  output  NUM_CH*WIDTH_OUT  lane k at [k*WIDTH_OUT +: WIDTH_OUT].
REQ-015 out_sat  output  NUM_CH  per-lane saturation flag for current out_data.
REQ-016 sat_clr  input  1  synchronous clear of sat_count.
REQ-017 sat_count  output  CNT_WIDTH  count of accepted output beats with any out_sat bit set.

Function
REQ-018 D = WIDTH_IN-WIDTH_OUT; per lane: trunc = din[WIDTH_IN-1:D] (floor), frac = din[D-1:0], half = 1<<(D-1).
REQ-019 inc: TRUNC 0; HALF_UP frac>=half; HALF_EVEN frac>half or (frac==half and trunc[0]); HALF_AWAY frac>half or (frac==half and not (IS_SIGNED and sign bit)).
REQ-020 sum = trunc + inc in WIDTH_OUT+1 bits (sign-extended if IS_SIGNED, zero-extended otherwise).
REQ-021 Signed overflow (sum[MSB]!=sum[MSB-1]) SHALL yield 0 followed by all ones (max positive), out_sat=1; unsigned carry SHALL yield all ones, out_sat=1; otherwise sum[WIDTH_OUT-1:0], out_sat=0.
REQ-022 D==0: inc=0, out_data=in_data, out_sat=0, all modes; latency unchanged.
REQ-023 Two register stages: S1 registers data, mode-derived inc, trunc; S2 registers rounded/saturated result and out_sat.
REQ-024 Latency SHALL be exactly 2 cycles from acceptance to out_valid with out_ready held high; throughput 1 beat/cycle.
REQ-025 Stage advances when downstream is empty or draining: S2 loads when !out_valid or out_ready; S1 loads when S1 empty or S2 loads; in_ready = S1 empty or S2 loads.
REQ-026 out_data, out_sat, out_valid SHALL hold stable while out_valid && !out_ready; no beat dropped or duplicated under any ready pattern.
REQ-027 Beats SHALL emerge in acceptance order; each beat uses its own sampled in_mode (mode changes per beat without bubbles).
REQ-028 sat_count increments on each output handshake with |out_sat; saturates at all ones (no wrap).
REQ-029 sat_clr with simultaneous counted handshake SHALL set sat_count = 1; sat_clr alone sets 0.

Reset
REQ-030 rst_n low SHALL asynchronously clear S1/S2 valid, out_valid=0, out_data=0, out_sat=0, sat_count=0.
REQ-031 in_ready SHALL be 0 while rst_n low and 1 on the first clk edge after release (pipeline empty).
REQ-032 Reset mid-stream SHALL discard all in-flight beats; no out_valid until a new beat is accepted post-reset.

Verification (NUM_CH=2, WIDTH_IN=8, WIDTH_OUT=4, IS_SIGNED=1 unless noted)
REQ-033 Lane0 0x18, lane1 0x28, mode HALF_EVEN -> out lanes 0x2, 0x2, out_sat=00, out_valid 2 cycles after accept.
REQ-034 Lane0 0xE8 (-1.5) in modes 0/1/2/3 back-to-back -> 0xE, 0xF, 0xE, 0xE in order, no bubbles.
REQ-035 Lane0 0x7F mode HALF_UP -> 0x7, out_sat[0]=1, sat_count 0->1 on handshake; IS_SIGNED=0 with 0xF8 -> 0xF, out_sat=1.
REQ-036 Random in_valid/out_ready (50%) with 1000 beats -> output stream equals reference model, stable data while stalled.
REQ-037 sat_count at all ones plus saturated beat -> stays all ones; sat_clr coincident with saturated handshake -> 1.
REQ-038 rst_n pulsed low with 2 beats in flight -> out_valid=0, sat_count=0 immediately; first post-reset output is the first post-reset input.

Source files
------------

// File: rtl/round_sat_pipe.sv
// Two-stage round-and-saturate pipeline: narrows NUM_CH lanes from WIDTH_IN to
// WIDTH_OUT bits with a per-beat rounding mode and counts saturated output beats.
module round_sat_pipe #(
    parameter int NUM_CH    = 1,
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 8,
    parameter int IS_SIGNED = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_CH*WIDTH_IN-1:0]  in_data,
    input  logic [1:0]                  in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CH*WIDTH_OUT-1:0] out_data,
    output logic [NUM_CH-1:0]           out_sat,
    input  logic                        sat_clr,
    output logic [CNT_WIDTH-1:0]        sat_count
);
    localparam int D = WIDTH_IN - WIDTH_OUT;
    localparam logic [WIDTH_OUT-1:0] ALL_ONES = {WIDTH_OUT{1'b1}};
    localparam logic [WIDTH_OUT-1:0] MAX_POS  = ALL_ONES >> 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    if (WIDTH_OUT < 1 || WIDTH_OUT > WIDTH_IN || NUM_CH < 1) begin : g_bad_param
        $error("round_sat_pipe: need NUM_CH >= 1 and 0 < WIDTH_OUT <= WIDTH_IN");
    end

    logic [NUM_CH*WIDTH_OUT-1:0] lane_trunc_s;
    logic [NUM_CH-1:0]           lane_inc_s;
    logic [NUM_CH*WIDTH_OUT-1:0] lane_res_s;
    logic [NUM_CH-1:0]           lane_sat_s;

    logic                        s1_valid_q, s1_valid_d;
    logic [NUM_CH*WIDTH_OUT-1:0] s1_trunc_q, s1_trunc_d;
    logic [NUM_CH-1:0]           s1_inc_q, s1_inc_d;
    logic                        out_valid_q, out_valid_d;
    logic [NUM_CH*WIDTH_OUT-1:0] out_data_q, out_data_d;
    logic [NUM_CH-1:0]           out_sat_q, out_sat_d;
    logic [CNT_WIDTH-1:0]        sat_count_q, sat_count_d;
    logic                        init_done_q, init_done_d;

    logic s2_load_s, s1_load_s, accept_s, sat_hit_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [WIDTH_IN-1:0]  din_s;
        logic [WIDTH_OUT-1:0] tq_s;
        logic [WIDTH_OUT:0]   sum_s;
        logic                 ext_s;
        logic                 ovf_s;

        assign din_s = in_data[k*WIDTH_IN +: WIDTH_IN];

        if (D == 0) begin : g_pass
            assign lane_trunc_s[k*WIDTH_OUT +: WIDTH_OUT] = din_s;
            assign lane_inc_s[k] = 1'b0;
        end else begin : g_round
            localparam logic [D-1:0] HALF = D'(1'b1) << (D - 1);
            logic [D-1:0] frac_s;
            logic         above_s, tie_s, neg_s, inc_s;

            assign frac_s  = din_s[D-1:0];
            assign above_s = (frac_s > HALF);
            assign tie_s   = (frac_s == HALF);
            assign neg_s   = (IS_SIGNED != 0) && din_s[WIDTH_IN-1];
            assign lane_trunc_s[k*WIDTH_OUT +: WIDTH_OUT] = din_s[WIDTH_IN-1:D];
            assign lane_inc_s[k] = inc_s;

            // rounding increment decode for this lane
            always_comb begin
                case (in_mode)
                    2'd0:    inc_s = 1'b0;
                    2'd1:    inc_s = above_s || tie_s;
                    2'd2:    inc_s = above_s || (tie_s && din_s[D]);
                    2'd3:    inc_s = above_s || (tie_s && !neg_s);
                    default: inc_s = 1'b0;
                endcase
            end
        end

        // Only upward overflow is possible since the increment is never negative.
        assign tq_s  = s1_trunc_q[k*WIDTH_OUT +: WIDTH_OUT];
        assign ext_s = (IS_SIGNED != 0) ? tq_s[WIDTH_OUT-1] : 1'b0;
        assign sum_s = {ext_s, tq_s} + {{WIDTH_OUT{1'b0}}, s1_inc_q[k]};
        assign ovf_s = (IS_SIGNED != 0) ? (sum_s[WIDTH_OUT] != sum_s[WIDTH_OUT-1])
                                        : sum_s[WIDTH_OUT];
        assign lane_sat_s[k] = ovf_s;
        assign lane_res_s[k*WIDTH_OUT +: WIDTH_OUT] =
            !ovf_s ? sum_s[WIDTH_OUT-1:0] : ((IS_SIGNED != 0) ? MAX_POS : ALL_ONES);
    end

    assign s2_load_s   = !out_valid_q || out_ready;
    assign s1_load_s   = !s1_valid_q || s2_load_s;
    assign in_ready    = init_done_q && s1_load_s;
    assign accept_s    = in_valid && in_ready;
    assign sat_hit_s   = out_valid_q && out_ready && (|out_sat_q);
    assign init_done_d = 1'b1;

    // stage 1 next state: capture truncated lanes and increments on accept
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_trunc_d = s1_trunc_q;
        s1_inc_d   = s1_inc_q;
        if (s1_load_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_trunc_d = lane_trunc_s;
                s1_inc_d   = lane_inc_s;
            end else begin
                s1_trunc_d = s1_trunc_q;
                s1_inc_d   = s1_inc_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // stage 2 next state: rounded/saturated result, held while stalled
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (s2_load_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = lane_res_s;
                out_sat_d  = lane_sat_s;
            end else begin
                out_data_d = out_data_q;
                out_sat_d  = out_sat_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // saturation-event counter; a clear coinciding with a hit leaves one count
    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = sat_hit_s ? CNT_WIDTH'(1'b1) : '0;
        end else if (sat_hit_s && (sat_count_q != CNT_MAX)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1'b1);
        end else begin
            sat_count_d = sat_count_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_trunc_q  <= '0;
            s1_inc_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            sat_count_q <= '0;
        end else begin
            init_done_q <= init_done_d;
            s1_valid_q  <= s1_valid_d;
            s1_trunc_q  <= s1_trunc_d;
            s1_inc_q    <= s1_inc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_round_sat_pipe.sv
// Scoreboard bench for round_sat_pipe: signed 2x8->4 instance against an
// arithmetic reference model, plus an unsigned instance with a 2-bit counter.
module tb_round_sat_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, sat_clr;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic [7:0]  out_data;
    logic [1:0]  out_sat;
    logic [15:0] sat_count;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, sat_clr2;
    logic [15:0] in_data2;
    logic [1:0]  in_mode2;
    logic [7:0]  out_data2;
    logic [1:0]  out_sat2;
    logic [1:0]  sat_count2;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] model_cnt;
    int          ready_mode = 0;
    logic        stall_prev;
    logic [7:0]  prev_data;
    logic [1:0]  prev_sat;

    always #5 clk = ~clk;

    round_sat_pipe #(.NUM_CH(2), .WIDTH_IN(8), .WIDTH_OUT(4), .IS_SIGNED(1), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    round_sat_pipe #(.NUM_CH(2), .WIDTH_IN(8), .WIDTH_OUT(4), .IS_SIGNED(0), .CNT_WIDTH(2)) u_dut_uns (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_mode(in_mode2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_sat(out_sat2),
        .sat_clr(sat_clr2), .sat_count(sat_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Exact arithmetic: floor of value/16, remainder decides the increment.
    function automatic exp_t ref_beat(input logic [15:0] din, input logic [1:0] mode);
        exp_t e;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            int v, fl, fr, inc, r;
            logic [7:0] b;
            b  = din[k*8 +: 8];
            v  = int'($signed(b));
            fl = v >>> 4;
            fr = v - fl * 16;
            case (mode)
                2'd1:    inc = (fr >= 8) ? 1 : 0;
                2'd2:    inc = (fr > 8 || (fr == 8 && (fl & 1) != 0)) ? 1 : 0;
                2'd3:    inc = (fr > 8 || (fr == 8 && v >= 0)) ? 1 : 0;
                default: inc = 0;
            endcase
            r = fl + inc;
            if (r > 7) begin
                e.data[k*4 +: 4] = 4'h7;
                e.sat[k]         = 1'b1;
            end else begin
                e.data[k*4 +: 4] = r[3:0];
                e.sat[k]         = 1'b0;
            end
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] l0, input logic [7:0] l1, input logic [1:0] m,
                        output int waited);
        int w = 0;
        in_valid = 1'b1;
        in_data  = {l1, l0};
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
        else sb_q.push_back(ref_beat({l1, l0}, m));
        waited = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // downstream ready and counter-clear generator
    initial begin : rdy
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            sat_clr = (ready_mode == 1) ? ($urandom_range(0, 15) == 0) : 1'b0;
        end
    end

    // output monitor: scoreboard pop, stall stability and counter model
    initial begin : mon
        exp_t e;
        logic hit;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_sat   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                chk("sat_count", sat_count, model_cnt);
                if (stall_prev) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_data", out_data, prev_data);
                    chk("hold_sat", out_sat, prev_sat);
                end
                hit = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_out", out_valid, 1'b0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("data", out_data, e.data);
                        chk("sat", out_sat, e.sat);
                        hit = |e.sat;
                    end
                end
                if (sat_clr) model_cnt = hit ? 16'd1 : 16'd0;
                else if (hit && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
                prev_sat   = out_sat;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        n_err++;
        $display("FAIL watchdog: time limit reached before the sequence completed");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mode    = 2'd0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_mode2   = 2'd0;
        out_ready2 = 1'b1;
        sat_clr2   = 1'b0;
        model_cnt  = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_sat", out_sat, 2'b00);
        chk("rst_sat_count", sat_count, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", in_ready, 1'b1);

        // half-even ties and two-cycle latency
        send(8'h18, 8'h28, 2'd2, w);
        @(negedge clk);
        chk("lat_s1_empty_out", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1'b1);
        chk("lat_out_data", out_data, 8'h22);
        chk("lat_out_sat", out_sat, 2'b00);
        @(posedge clk); #1;

        // -1.5 through all four modes back to back
        for (int m = 0; m < 4; m++) begin
            send(8'hE8, 8'h00, m[1:0], w);
            chk("no_bubble", w, 0);
        end
        drain();

        // signed positive overflow
        send(8'h7F, 8'h00, 2'd1, w);
        drain();
        chk("sat_cnt_first", sat_count, 16'd1);

        // unsigned instance: carry saturation, counter saturation and clears
        in_valid2 = 1'b1;
        in_data2  = {8'h10, 8'hF8};
        in_mode2  = 2'd1;
        repeat (4) begin @(posedge clk); #1; end
        in_valid2 = 1'b0;
        chk("uns_valid", out_valid2, 1'b1);
        chk("uns_data", out_data2, 8'h1F);
        chk("uns_sat", out_sat2, 2'b01);
        chk("uns_cnt_mid", sat_count2, 2'd2);
        repeat (3) begin @(posedge clk); #1; end
        chk("uns_cnt_stuck", sat_count2, 2'd3);
        chk("uns_idle", out_valid2, 1'b0);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        sat_clr2 = 1'b1;
        @(posedge clk); #1;
        sat_clr2 = 1'b0;
        chk("uns_clr_with_hit", sat_count2, 2'd1);
        sat_clr2 = 1'b1;
        @(posedge clk); #1;
        sat_clr2 = 1'b0;
        chk("uns_clr_only", sat_count2, 2'd0);

        // random traffic with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), w);
            while ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
        ready_mode = 0;
        drain();

        // reset with two beats in flight
        send(8'h7F, 8'h00, 2'd1, w);
        drain();
        ready_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        send(8'h11, 8'h22, 2'd0, w);
        send(8'h33, 8'h44, 2'd0, w);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_sat_count", sat_count, 16'd0);
        chk("midrst_in_ready", in_ready, 1'b0);
        sb_q.delete();
        model_cnt = '0;
        #4;
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk); #1;
        chk("post_rst_no_stale", out_valid, 1'b0);
        send(8'h30, 8'h40, 2'd0, w);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
